// File: rtl/temp_to_vtherm.sv
// Inverse thermistor conversion: temperature in C to 8-bit ADC code.
// Ports: clk, rst (async high), start/temp_in in; busy, done, v_out, range_err out.
module temp_to_vtherm (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] temp_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] v_out,
  output logic       range_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    MUL,
    OUT
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  temp_q;
  logic [7:0]  base_q;
  logic [5:0]  diff_q;
  logic [9:0]  acc_q;
  logic [1:0]  cnt_q;
  logic        err_q;

  logic [2:0]  seg;
  logic [3:0]  seg_lo;
  logic [3:0]  seg_hi;
  logic [7:0]  t_lo;
  logic [7:0]  t_hi;
  logic [7:0]  t_diff;
  logic [9:0]  addend;
  logic [9:0]  rnd;

  function automatic logic [7:0] tbl(input logic [3:0] k);
    logic [7:0] r;
    unique case (k)
      4'd0:    r = 8'd191;
      4'd1:    r = 8'd151;
      4'd2:    r = 8'd110;
      4'd3:    r = 8'd76;
      4'd4:    r = 8'd52;
      4'd5:    r = 8'd35;
      4'd6:    r = 8'd24;
      4'd7:    r = 8'd16;
      default: r = 8'd12;
    endcase
    return r;
  endfunction

  assign seg    = temp_q[6:4];
  assign seg_lo = {1'b0, seg};
  assign seg_hi = seg_lo + 4'd1;
  assign t_lo   = tbl(seg_lo);
  assign t_hi   = tbl(seg_hi);
  // Adjacent breakpoints never differ by more than 41, so 6 bits suffice.
  assign t_diff = t_lo - t_hi;
  assign addend = {4'b0, diff_q} << cnt_q;
  // Adding half an LSB before the shift gives round-half-up.
  assign rnd    = acc_q + 10'd8;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: state_nx = MUL;
      MUL:   if (cnt_q == 2'd3) state_nx = OUT;
      OUT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_q    <= '0;
      base_q    <= '0;
      diff_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done      <= 1'b0;
      v_out     <= '0;
      range_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) temp_q <= temp_in;
        end
        FETCH: begin
          acc_q <= '0;
          cnt_q <= '0;
          err_q <= (temp_q > 8'd128);
          if (temp_q[7]) begin
            base_q <= 8'd12;
            diff_q <= '0;
          end else begin
            base_q <= t_lo;
            diff_q <= t_diff[5:0];
          end
        end
        MUL: begin
          if (temp_q[cnt_q]) acc_q <= acc_q + addend;
          cnt_q <= cnt_q + 2'd1;
        end
        OUT: begin
          v_out     <= base_q - {2'b0, rnd[9:4]};
          range_err <= err_q;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_to_vtherm.sv
// Directed and sweep bench for temp_to_vtherm.
// Drives on negedge, samples 1 ns after posedge.
module tb_temp_to_vtherm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] temp_in = '0;
  logic       busy;
  logic       done;
  logic [7:0] v_out;
  logic       range_err;

  int errors = 0;
  int checks = 0;

  temp_to_vtherm dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .temp_in   (temp_in),
    .busy      (busy),
    .done      (done),
    .v_out     (v_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] t;
    logic [7:0] v;
    logic       e;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_v(input int t);
    int tb_t[9];
    int s, f, d;
    tb_t = '{191, 151, 110, 76, 52, 35, 24, 16, 12};
    if (t >= 128) return 12;
    s = t / 16;
    f = t % 16;
    d = tb_t[s] - tb_t[s + 1];
    return tb_t[s] - ((d * f + 8) / 16);
  endfunction

  // Runs one conversion; returns result and latency (0 = timed out).
  task automatic convert(input logic [7:0] t, output int v,
                         output int e, output int lat);
    @(negedge clk);
    start = 1'b1;
    temp_in = t;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    v = -1;
    e = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        v = v_out;
        e = range_err;
        break;
      end
    end
  endtask

  initial begin
    int v, e, lat, cnt, prev, vsave;
    int pos[$];

    vecs[0] = '{8'd0,   8'd191, 1'b0};
    vecs[1] = '{8'd25,  8'd128, 1'b0};
    vecs[2] = '{8'd40,  8'd93,  1'b0};
    vecs[3] = '{8'd15,  8'd153, 1'b0};
    vecs[4] = '{8'd112, 8'd16,  1'b0};
    vecs[5] = '{8'd127, 8'd12,  1'b0};
    vecs[6] = '{8'd128, 8'd12,  1'b0};
    vecs[7] = '{8'd129, 8'd12,  1'b1};
    vecs[8] = '{8'd255, 8'd12,  1'b1};

    #3 rst = 1'b1;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset v_out", v_out, 0);
    chk("reset range_err", range_err, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("idle no done", cnt, 0);

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].t, v, e, lat);
      chk($sformatf("v_out t=%0d", vecs[i].t), v, vecs[i].v);
      chk($sformatf("range_err t=%0d", vecs[i].t), e, vecs[i].e);
      chk($sformatf("latency t=%0d", vecs[i].t), lat, 6);
    end

    // Second start and temp change during busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    temp_in = 8'd40;
    @(posedge clk);
    #1;
    chk("busy after accept", busy, 1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    temp_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    vsave = -1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        vsave = v_out;
      end
    end
    chk("ignored start done count", cnt, 1);
    chk("ignored start v_out", vsave, 93);

    // Start held high: done every 7 clocks.
    @(negedge clk);
    start = 1'b1;
    temp_in = 8'd0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk);
      #1;
      if (done) pos.push_back(k);
    end
    @(negedge clk);
    start = 1'b0;
    chk("held start done count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("held first done", pos[0], 6);
      chk("held gap1", pos[1] - pos[0], 7);
      chk("held gap2", pos[2] - pos[1], 7);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("drained busy", busy, 0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1;
    temp_in = 8'd25;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset v_out", v_out, 0);
    chk("midreset range_err", range_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("aborted no done", cnt, 0);
    convert(8'd0, v, e, lat);
    chk("post reset v_out", v, 191);
    chk("post reset latency", lat, 6);

    // Full sweep against the reference formula.
    prev = 255;
    for (int t = 0; t < 256; t++) begin
      convert(t[7:0], v, e, lat);
      chk($sformatf("sweep v t=%0d", t), v, ref_v(t));
      chk($sformatf("sweep err t=%0d", t), e, (t > 128) ? 1 : 0);
      chk($sformatf("sweep mono t=%0d", t), (v <= prev) ? 1 : 0, 1);
      prev = v;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
